// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared constants for the MicroUAZ ALU sequencer slice.
//   N_DEF / AW_DEF : default datapath width and register address width
//   OP_*           : 3-bit opcode encoding understood by alu_core
//   S_*            : sequencer FSM state encoding
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  localparam int N_DEF  = 8;
  localparam int AW_DEF = 2;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_LDI = 3'b111;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational N-bit ALU shared by the sequencer.
// Ports:
//   a, b  in  N  operands (b carries the immediate for LDI)
//   op    in  3  opcode (see alu_seq_pkg OP_*)
//   y     out N  result
//   c     out 1  ADD carry-out / SUB borrow; 0 for all other ops
// ---------------------------------------------------------------------------
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  output logic [N-1:0] y,
  output logic         c
);

  logic [N:0] sum;
  logic [N:0] diff;

  // Both arithmetic paths are formed one bit wider so the top bit is the
  // carry for ADD and, through two's-complement wrap, the borrow for SUB.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    y    = '0;
    c    = 1'b0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOT: y = ~a;
      OP_ADD: begin
        y = sum[N-1:0];
        c = sum[N];
      end
      OP_SUB: begin
        y = diff[N-1:0];
        c = diff[N];
      end
      OP_MOV: y = b;
      OP_LDI: y = b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Multi-cycle controller for the MicroUAZ ALU: accepts one command over
// valid/ready, fetches operands from an internal register file, runs the
// shared alu_core, registers result/flags and writes the result back to rd.
// Sequence: IDLE -> FETCH -> EXEC -> DONE -> IDLE (one command per 4 cycles).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   command handshake (ready only in IDLE)
//   cmd_op/rd/ra/rb   opcode, destination and source registers
//   cmd_imm           immediate for LDI
//   done              one-cycle completion pulse (rd already written)
//   result, flag_z,   last completed result and its flags, held until the
//   flag_c            next completion
//   dbg_addr/dbg_data combinational register-file read port
// ---------------------------------------------------------------------------
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic [N-1:0]  cmd_imm,
  output logic          done,
  output logic [N-1:0]  result,
  output logic          flag_z,
  output logic          flag_c,
  input  logic [AW-1:0] dbg_addr,
  output logic [N-1:0]  dbg_data
);

  localparam int NREG = 2 ** AW;

  logic [1:0]    state_q, state_d;
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q, ra_q, rb_q;
  logic [N-1:0]  imm_q;
  logic [N-1:0]  opa_q, opb_q;
  logic [N-1:0]  result_q;
  logic          z_q, c_q;
  logic [N-1:0]  rf_q [NREG];

  logic [N-1:0]  alu_y;
  logic          alu_c;

  alu_core #(.N(N)) u_alu (
    .a  (opa_q),
    .b  (opb_q),
    .op (op_q),
    .y  (alu_y),
    .c  (alu_c)
  );

  // Every state after IDLE lasts exactly one cycle, so only the IDLE exit
  // depends on an input.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command capture, operand fetch and write-back. The register file is only
  // written in EXEC, so a reset arriving in FETCH/EXEC/DONE leaves nothing
  // half-done; the next command can FETCH only after the previous write,
  // which makes back-to-back read-after-write safe without forwarding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      imm_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && cmd_valid) begin
        op_q  <= cmd_op;
        rd_q  <= cmd_rd;
        ra_q  <= cmd_ra;
        rb_q  <= cmd_rb;
        imm_q <= cmd_imm;
      end
      if (state_q == S_FETCH) begin
        opa_q <= rf_q[ra_q];
        opb_q <= (op_q == OP_LDI) ? imm_q : rf_q[rb_q];
      end
      if (state_q == S_EXEC) begin
        result_q   <= alu_y;
        z_q        <= (alu_y == '0);
        c_q        <= alu_c;
        rf_q[rd_q] <= alu_y;
      end
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign dbg_data  = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
// Scoreboard bench for alu_sequencer: the stimulus process predicts each
// command's outcome with a plain-arithmetic register-file model and queues
// it; a monitor pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

  localparam int N    = 8;
  localparam int AW   = 2;
  localparam int NREG = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rd, cmd_ra, cmd_rb;
  logic [N-1:0]  cmd_imm;
  logic          done;
  logic [N-1:0]  result;
  logic          flag_z, flag_c;
  logic [AW-1:0] dbg_addr;
  logic [N-1:0]  dbg_data;

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       c;
    int         doneEdge;
  } expect_t;

  expect_t    sbQueue[$];
  int         checks = 0;
  int         errors = 0;
  int         edgeCount = 0;
  logic [7:0] modelRegs [NREG];

  alu_sequencer #(.N(N), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_ra    (cmd_ra),
    .cmd_rb    (cmd_rb),
    .cmd_imm   (cmd_imm),
    .done      (done),
    .result    (result),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Rising-edge counter used to check completion latency.
  always @(posedge clk) edgeCount <= edgeCount + 1;

  // Single comparison point: every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at edge %0d",
               name, actual, expected, edgeCount);
    end
  endtask

  // Reference semantics of one instruction, straight from the opcode table.
  function automatic void refAlu(input int op, input int a, input int b,
                                 input int imm, output logic [7:0] res,
                                 output logic c);
    int r;
    c = 1'b0;
    case (op)
      0: r = a & b;
      1: r = a | b;
      2: r = a ^ b;
      3: r = 255 - a;
      4: begin r = a + b; c = (r > 255); end
      5: begin r = a - b; c = (a < b); if (r < 0) r = r + 256; end
      6: r = b;
      default: r = imm;
    endcase
    res = r[7:0];
  endfunction

  // Monitor: every done pulse must match the oldest queued prediction,
  // arriving exactly two edges after its accepting edge.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpectedDone", 32'(done), 32'd0);
      end else begin
        expect_t e;
        e = sbQueue.pop_front();
        checkOutput("result", 32'(result), 32'(e.res));
        checkOutput("flagZ", 32'(flag_z), 32'(e.z));
        checkOutput("flagC", 32'(flag_c), 32'(e.c));
        checkOutput("doneLatency", 32'(edgeCount), 32'(e.doneEdge));
      end
    end
  end

  // Issue one command from a negedge; returns at the IDLE negedge after DONE.
  // Fields are scrambled after acceptance to prove only the accept edge
  // samples them. With hold set, cmd_valid stays high into the next command.
  task automatic applyStimulus(input int op, input int rd, input int ra,
                               input int rb, input int imm, input bit hold);
    int waitCount;
    expect_t e;
    logic [7:0] res;
    logic c;
    cmd_op    = 3'(op);
    cmd_rd    = 2'(rd);
    cmd_ra    = 2'(ra);
    cmd_rb    = 2'(rb);
    cmd_imm   = 8'(imm);
    cmd_valid = 1'b1;
    waitCount = 0;
    while (cmd_ready !== 1'b1 && waitCount < 10) begin
      @(negedge clk);
      waitCount++;
    end
    checkOutput("acceptTimeout", 32'(cmd_ready), 32'd1);
    if (cmd_ready !== 1'b1) begin
      cmd_valid = 1'b0;
      return;
    end
    refAlu(op, int'(modelRegs[ra]), int'(modelRegs[rb]), imm, res, c);
    e.res      = res;
    e.z        = (res == 8'h00);
    e.c        = c;
    e.doneEdge = edgeCount + 3;
    sbQueue.push_back(e);
    modelRegs[rd] = res;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        cmd_op  = 3'($urandom);
        cmd_rd  = 2'($urandom);
        cmd_ra  = 2'($urandom);
        cmd_rb  = 2'($urandom);
        cmd_imm = 8'($urandom);
      end
      checkOutput("readyBusy", 32'(cmd_ready), 32'd0);
    end
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Compare the whole register file through the debug port.
  task automatic checkRegs();
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = 2'(i);
      #1;
      checkOutput($sformatf("dbgReg%0d", i), 32'(dbg_data), 32'(modelRegs[i]));
    end
  endtask

  initial begin
    int waitCount;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_rd    = '0;
    cmd_ra    = '0;
    cmd_rb    = '0;
    cmd_imm   = '0;
    dbg_addr  = '0;
    for (int i = 0; i < NREG; i++) modelRegs[i] = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetResult", 32'(result), 32'd0);
    checkOutput("resetZ", 32'(flag_z), 32'd0);
    checkOutput("resetC", 32'(flag_c), 32'd0);
    checkOutput("resetReady", 32'(cmd_ready), 32'd1);
    checkRegs();

    applyStimulus(7, 1, 0, 0, 8'hF0, 0);
    applyStimulus(7, 2, 0, 0, 8'h3C, 0);
    applyStimulus(0, 3, 1, 2, 0, 0);
    checkRegs();

    applyStimulus(7, 0, 0, 0, 8'hFF, 0);
    applyStimulus(7, 1, 0, 0, 8'h01, 0);
    applyStimulus(4, 2, 0, 1, 0, 0);
    applyStimulus(5, 3, 1, 0, 0, 0);
    checkRegs();

    applyStimulus(7, 1, 0, 0, 8'h01, 0);
    applyStimulus(4, 1, 1, 1, 0, 1);
    applyStimulus(4, 1, 1, 1, 0, 1);
    applyStimulus(4, 1, 1, 1, 0, 0);
    checkRegs();

    applyStimulus(7, 2, 0, 0, 8'h11, 0);
    cmd_op    = 3'd7;
    cmd_rd    = 2'd2;
    cmd_imm   = 8'h55;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) modelRegs[i] = 8'h00;
    checkOutput("abortDone", 32'(done), 32'd0);
    checkOutput("abortReady", 32'(cmd_ready), 32'd1);
    checkOutput("abortResult", 32'(result), 32'd0);
    checkRegs();
    applyStimulus(7, 3, 0, 0, 8'h77, 0);

    applyStimulus(7, 0, 0, 0, 8'hA5, 0);
    applyStimulus(3, 1, 0, int'($urandom_range(0, 3)), 0, 0);
    applyStimulus(2, 0, 0, 0, 0, 0);
    checkRegs();

    for (int k = 0; k < 40; k++) begin
      applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    checkRegs();

    waitCount = 0;
    while (sbQueue.size() != 0 && waitCount < 20) begin
      @(negedge clk);
      waitCount++;
    end
    checkOutput("scoreboardDrain", 32'(sbQueue.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
